// File: rtl/gbar_arb_ctrl.sv
// gbar_arb_ctrl: round-robin arbitrates core barrier requests, counts arrivals per id
// and broadcasts a one-cycle release carrying the id when the last participant arrives.
module gbar_arb_ctrl #(
    parameter int NUM_REQS     = 4,
    parameter int NUM_BARRIERS = 8,
    parameter int NB_WIDTH     = $clog2(NUM_BARRIERS),
    parameter int NC_WIDTH     = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQS-1:0]          req_valid,
    input  logic [NUM_REQS*NB_WIDTH-1:0] req_id,
    input  logic [NUM_REQS*NC_WIDTH-1:0] req_size_m1,
    input  logic [NUM_REQS*NC_WIDTH-1:0] req_core_id,
    output logic [NUM_REQS-1:0]          req_ready,
    output logic                         rsp_valid,
    output logic [NB_WIDTH-1:0]          rsp_id,
    output logic [NUM_BARRIERS-1:0]      barrier_pending
);
    localparam int PW = NUM_REQS > 1 ? $clog2(NUM_REQS) : 1;

    logic [PW-1:0]           rr_q, rr_d, gnt_idx, cand;
    logic                    gnt_found, hs;
    logic [NB_WIDTH-1:0]     sel_id, rsp_id_q, rsp_id_d;
    logic [NC_WIDTH-1:0]     sel_size;
    logic [NC_WIDTH-1:0]     count_q [NUM_BARRIERS];
    logic [NC_WIDTH-1:0]     count_d [NUM_BARRIERS];
    logic [NUM_BARRIERS-1:0] pend_q, pend_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    unused_core_id;

    assign unused_core_id = ^req_core_id;

    // first valid port at or after rr_q wins
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQS; k++) begin
            cand = PW'((int'(rr_q) + k) % NUM_REQS);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign hs        = gnt_found && !reset;
    assign req_ready = hs ? NUM_REQS'(1) << gnt_idx : '0;
    assign sel_id    = req_id[int'(gnt_idx)*NB_WIDTH +: NB_WIDTH];
    assign sel_size  = req_size_m1[int'(gnt_idx)*NC_WIDTH +: NC_WIDTH];
    assign rr_d      = hs ? ((int'(gnt_idx) == NUM_REQS - 1) ? '0 : gnt_idx + 1'b1) : rr_q;

    // >= keeps a barrier from hanging if software mixes sizes for one id
    always_comb begin
        count_d     = count_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        if (hs) begin
            if (count_q[sel_id] >= sel_size) begin
                count_d[sel_id] = '0;
                rsp_valid_d     = 1'b1;
                rsp_id_d        = sel_id;
            end else begin
                count_d[sel_id] = count_q[sel_id] + 1'b1;
            end
        end
        for (int b = 0; b < NUM_BARRIERS; b++)
            pend_d[b] = count_d[b] != '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q        <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            pend_q      <= '0;
            for (int b = 0; b < NUM_BARRIERS; b++)
                count_q[b] <= '0;
        end else begin
            rr_q        <= rr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            pend_q      <= pend_d;
            count_q     <= count_d;
        end
    end

    assign rsp_valid       = rsp_valid_q;
    assign rsp_id          = rsp_id_q;
    assign barrier_pending = pend_q;
endmodule

// File: doc/gbar_arb_ctrl.md
# gbar_arb_ctrl

Global barrier controller that sits on the slave side of the global-barrier bus, between the per-core barrier request ports and the cluster-wide barrier state. It round-robin arbitrates up to NUM_REQS core requests, one per cycle. It counts arrivals per barrier id and broadcasts a single-cycle release response carrying the barrier id once the last participant arrives. Cores wake all warps waiting on that id when they see the release.

## Interface
- NUM_REQS, 4: number of core-side request ports arbitrated.
- NUM_BARRIERS, 8: number of global barrier ids tracked.
- NB_WIDTH, $clog2(NUM_BARRIERS): barrier id width.
- NC_WIDTH, 4: core id / participant-count width.

Ports:
- clk  input  1: clock; all logic on rising edge.
- reset  input  1: synchronous, active-high reset.
- req_valid  input  NUM_REQS: per-port request valid.
- req_id  input  NUM_REQS*NB_WIDTH: per-port barrier id; port i occupies bits [i*NB_WIDTH +: NB_WIDTH].
- req_size_m1  input  NUM_REQS*NC_WIDTH: participating cores minus one.
- req_core_id  input  NUM_REQS*NC_WIDTH: requesting core id; carried for trace only, no functional effect.
- req_ready  output  NUM_REQS: per-port accept; one-hot or zero.
- rsp_valid  output  1: release pulse broadcast to all cores; no ready, cannot stall.
- rsp_id  output  NB_WIDTH: released barrier id, valid with rsp_valid.
- barrier_pending  output  NUM_BARRIERS: bit b set while barrier b has at least one recorded arrival.

## Operation
- Arbiter: combinational round-robin over req_valid, with priority pointer rr_ptr.
  - req_ready[g] is asserted only for the granted port g, and only when any req_valid is set and reset is low.
  - Handshake occurs on req_valid[g] && req_ready[g].
- rr_ptr update: after a handshake on port g, rr_ptr = (g+1) mod NUM_REQS. With no handshake, rr_ptr holds. Reset sets rr_ptr = 0, making port 0 highest priority.
- Per-barrier state: count[b] (NC_WIDTH bits) holds arrivals so far.
- On a handshake with id b and size s:
  - count[b] == s: release. Set count[b] = 0 and register rsp_valid = 1, rsp_id = b.
  - Otherwise: count[b] = count[b] + 1, with no response.
- The comparison uses the size presented with the current request. Mixed sizes for one id are a software error; no checking is done.
- s = 0 is a single-participant barrier: it releases immediately and count stays 0.
- count never exceeds s, so there is no overflow at width NC_WIDTH. If count[b] > s because of inconsistent sizes, treat it as release (use >=) so the barrier cannot hang.
- At most one handshake per cycle, so there are no same-cycle update conflicts. Back-to-back releases of the same or different ids are legal on consecutive cycles.
- barrier_pending[b] = (count[b] != 0), registered from the count state.
- Requests with valid high and ready low must hold their payload stable; this block does not buffer requests.

## Timing
- Reset values: rsp_valid 0, rsp_id 0, barrier_pending all 0, every count 0, rr_ptr 0. While reset is high, req_ready is all 0.
- Release latency: handshake in cycle N, rsp_valid high during cycle N+1 for exactly one cycle, unless cycle N+1 also releases.
- Counting latency: count and barrier_pending reflect a handshake in cycle N from cycle N+1.
- req_ready is combinational from req_valid and rr_ptr in the same cycle. There is no combinational path from rsp to req.
- Reset asserted mid-operation:
  - All partial counts are discarded.
  - A release registered in the same cycle is dropped, so rsp_valid is 0 on the cycle after reset.
  - Arbitration resumes from port 0 on the first cycle with reset low.

## Test plan
- Reset: hold reset 3 cycles with all req_valid = 1. Required: req_ready = 0, rsp_valid = 0, barrier_pending = 0 throughout. After release from reset, first grant goes to port 0.
- Basic barrier: ports 0..3 each issue id 2, size_m1 3, presented together. Required:
  - Grants 0,1,2,3 on 4 consecutive cycles.
  - barrier_pending[2] = 1 after the first grant.
  - Single rsp_valid with rsp_id 2 the cycle after the 4th grant, then barrier_pending[2] = 0.
- Single participant: port 1 issues id 5, size_m1 0. Required: rsp_valid with rsp_id 5 the next cycle, and barrier_pending[5] never set.
- Fairness: port 0 holds valid continuously (ids cycling 0..7, size 7) while port 2 requests once. Required: port 2 is granted within 2 cycles, with grant order 0,2,0 and no starvation.
- Interleaved ids: alternate id 1 and id 3, size_m1 1, across ports 0..3. Required: releases for id 1 then id 3 on consecutive cycles, with rsp_id correct each cycle.
- Mid-operation reset: with count[4] = 2 and a release registered, pulse reset for 1 cycle. Required: no rsp_valid afterward and count[4] = 0. A new size_m1 1 barrier on id 4 then needs 2 fresh arrivals.
